// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter.
// FSM states, owner encoding and store byte-mask constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int WMASK_W = 8;

  localparam logic [WMASK_W-1:0] MASK_D = 8'hff;
  localparam logic [WMASK_W-1:0] MASK_W = 8'h0f;
  localparam logic [WMASK_W-1:0] MASK_H = 8'h03;
  localparam logic [WMASK_W-1:0] MASK_B = 8'h01;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle of the arbiter: IFU and LSU request/response channels
// plus the memory-bridge side. slave = arbiter, master = environment.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN = 64
);

  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [XLEN-1:0]    ifu_req_addr;
  logic               ifu_resp_valid;
  logic               ifu_resp_ready;
  logic [XLEN-1:0]    ifu_resp_data;

  logic               lsu_req_valid;
  logic               lsu_req_ready;
  logic [XLEN-1:0]    lsu_req_addr;
  logic               lsu_req_wen;
  logic [XLEN-1:0]    lsu_req_wdata;
  logic [WMASK_W-1:0] lsu_req_wmask;
  logic               lsu_resp_valid;
  logic               lsu_resp_ready;
  logic [XLEN-1:0]    lsu_resp_data;

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_req_wen;
  logic [XLEN-1:0]    mem_req_wdata;
  logic [WMASK_W-1:0] mem_req_wmask;
  logic               mem_resp_valid;
  logic [XLEN-1:0]    mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
    input  lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen,
    output mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen,
    output lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen,
    input  mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Pick rule (LSU priority, bounded IFU starvation) and streak counter.
// Ports: ifu/lsu valids, grant fire strobe in; winner and streak out.
module mem_arb_grant
  import mem_arbiter_pkg::*;
#(
  parameter  int MAX_LSU_STREAK = 4,
  localparam int SW = $clog2(MAX_LSU_STREAK + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_valid_i,
  input  logic          lsu_valid_i,
  input  logic          fire_i,
  output owner_e        winner_o,
  output logic [SW-1:0] streak_o
);

  localparam logic [SW-1:0] MAX_S = SW'(MAX_LSU_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          starved;

  assign starved  = ifu_valid_i && (streak_q == MAX_S);
  assign streak_o = streak_q;

  always_comb begin
    winner_o = OWN_IFU;
    if (lsu_valid_i && !starved)
      winner_o = OWN_LSU;
  end

  // Streak only grows while IFU is actually waiting.
  always_comb begin
    streak_d = streak_q;
    if (fire_i) begin
      if (winner_o == OWN_LSU && ifu_valid_i)
        streak_d = (streak_q == MAX_S) ? MAX_S
                                       : streak_q + SW'(1);
      else
        streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) streak_q <= '0;
    else      streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of IFU and LSU onto one memory port.
// Ports: clk, rst (sync, active-low) and the bus interface (slave).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int XLEN           = 64,
  parameter  int MAX_LSU_STREAK = 4,
  localparam int SW = $clog2(MAX_LSU_STREAK + 1)
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [WMASK_W-1:0] wmask_q, wmask_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;

  owner_e        winner;
  logic [SW-1:0] streak_unused;
  logic          idle;
  logic          ifu_rdy;
  logic          lsu_rdy;
  logic          fire;
  logic          resp_rdy;

  mem_arb_grant #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .ifu_valid_i (bus.ifu_req_valid),
    .lsu_valid_i (bus.lsu_req_valid),
    .fire_i      (fire),
    .winner_o    (winner),
    .streak_o    (streak_unused)
  );

  // No handshake while reset is held, so nothing is granted and lost.
  assign idle    = (state_q == ST_IDLE) && rst;
  assign ifu_rdy = idle && (winner == OWN_IFU)
                        && bus.ifu_req_valid;
  assign lsu_rdy = idle && (winner == OWN_LSU)
                        && bus.lsu_req_valid;
  assign fire    = ifu_rdy || lsu_rdy;

  assign resp_rdy = (owner_q == OWN_LSU) ? bus.lsu_resp_ready
                                         : bus.ifu_resp_ready;

  assign bus.ifu_req_ready  = ifu_rdy;
  assign bus.lsu_req_ready  = lsu_rdy;
  assign bus.mem_req_valid  = (state_q == ST_ISSUE);
  assign bus.mem_req_addr   = addr_q;
  assign bus.mem_req_wen    = wen_q;
  assign bus.mem_req_wdata  = wdata_q;
  assign bus.mem_req_wmask  = wmask_q;
  assign bus.ifu_resp_valid = (state_q == ST_RESP)
                              && (owner_q == OWN_IFU);
  assign bus.lsu_resp_valid = (state_q == ST_RESP)
                              && (owner_q == OWN_LSU);
  assign bus.ifu_resp_data  = rdata_q;
  assign bus.lsu_resp_data  = rdata_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lsu_rdy) begin
          state_d = ST_ISSUE;
          owner_d = OWN_LSU;
          addr_d  = bus.lsu_req_addr;
          wen_d   = bus.lsu_req_wen;
          wdata_d = bus.lsu_req_wdata;
          // Loads carry no byte enables to memory.
          wmask_d = bus.lsu_req_wen ? bus.lsu_req_wmask
                                    : '0;
        end else if (ifu_rdy) begin
          state_d = ST_ISSUE;
          owner_d = OWN_IFU;
          addr_d  = bus.ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_req_ready)
          state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_resp_valid) begin
          state_d = ST_RESP;
          rdata_d = wen_q ? '0 : bus.mem_resp_data;
        end
      end
      ST_RESP: begin
        if (resp_rdy)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single data-memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write with byte mask).
- Sits between the fetch/LSU front ends of the ysyx_22050039 RV64 core and the memory bridge.
- Holds one outstanding transaction at a time.
- Arbitration is LSU-priority with a bounded anti-starvation streak for IFU.

Parameters:
XLEN, 64, address/data width
MAX_LSU_STREAK, 4, maximum consecutive LSU grants while IFU waits (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-low (asserted when rst==0)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  XLEN  fetch address
ifu_resp_valid  out  1  fetch data valid
ifu_resp_ready  in  1  IFU takes response
ifu_resp_data  out  XLEN  fetched doubleword
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  XLEN  load/store address
lsu_req_wen  in  1  1=store, 0=load
lsu_req_wdata  in  XLEN  store data
lsu_req_wmask  in  8  store byte mask (8'hff sd, 8'hf sw, 8'h3 sh, 8'h1 sb)
lsu_resp_valid  out  1  load data / store ack valid
lsu_resp_ready  in  1  LSU takes response
lsu_resp_data  out  XLEN  load data; 0 for store ack
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  registered address
mem_req_wen  out  1  registered write enable
mem_req_wdata  out  XLEN  registered write data
mem_req_wmask  out  8  registered mask; 0 on reads
mem_resp_valid  in  1  memory response (reads and write acks)
mem_resp_data  in  XLEN  read data

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, streak=0, owner=IFU.
  - All *_valid and *_ready outputs 0; data/addr/mask registers 0.
  - Reset mid-transaction abandons it; the pending response is discarded.
  - A later mem_resp_valid in IDLE is ignored.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Picker selects the winner. Exactly one of ifu_req_ready/lsu_req_ready is driven combinationally high, for the winner only, and only if its valid is high.
  - On handshake, latch addr/wen/wdata/wmask/owner and go to ISSUE. IFU latches wen=0, wmask=0.
- Pick rule:
  - Only one requester valid -> it wins.
  - Both valid -> LSU wins unless streak==MAX_LSU_STREAK, in which case IFU wins.
- Streak update on each grant:
  - LSU granted while ifu_req_valid=1 -> streak+1, saturating at MAX_LSU_STREAK.
  - LSU granted with ifu_req_valid=0 -> streak=0.
  - IFU granted -> streak=0.
- ISSUE: mem_req_valid=1 with the latched fields held stable. On mem_req_ready go to WAIT; otherwise stay.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: capture mem_resp_data (forced 0 if wen) and go to RESP.
  - Memory never responds in the cycle its request is accepted; a mem_resp_valid outside WAIT is ignored.
- RESP:
  - The owner's resp_valid=1 with captured data, held until the owner's resp_ready. Then go to IDLE.
  - The non-owner's resp_valid stays 0.
- No new request is accepted before RESP completes. Both req_ready are 0 outside IDLE.
- Minimum latency: accept at cycle N, mem_req at N+1 (ready same cycle), response at N+2, resp_valid at N+3; next accept at N+4.
- Requesters must hold valid and payload until ready. The arbiter never drops an asserted request.
- Address alignment is not checked; sub-doubleword extraction stays in the LSU.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - WMASK_W=8
  - mask constants MASK_D/W/H/B
- One sub-module, mem_arb_grant: the combinational pick rule plus the registered streak counter. Inputs are both valids, a grant-fire strobe and reset; outputs are the winner and streak.

Test Plan:
1. IFU-only read at 0x80000000, memory returns 0x00100073_00000413 after 1 cycle -> ifu_resp_data equals it at N+3; lsu_resp_valid stays 0.
2. LSU sd to 0x80001000, wdata 0x1122334455667788, mask 8'hff, then ld from the same address -> mem_req_wmask 8'hff then 8'h00; lsu_resp_data 0 for the store, then 0x1122334455667788.
3. Both requesters valid continuously, MAX_LSU_STREAK=4 -> grant order L,L,L,L,I,L,L,L,L,I; streak resets after each I.
4. mem_req_ready low for 3 cycles in ISSUE, then lsu_resp_ready low for 2 cycles in RESP -> mem_req fields stable, resp_valid held, no new ready until RESP completes.
5. rst=0 asserted in WAIT, mem_resp_valid arrives 1 cycle after rst returns high -> response ignored, no resp_valid, next IFU request serviced normally.
6. LSU store with wmask 8'h1 while IFU valid, memory ack only -> lsu_resp_data 0, streak=1, IFU granted next.
